lcs_engine: RTL and testbench

- Parametrised longest-common-subsequence / longest-common-substring engine for the button/LCD lab designs.
- Two strings of up to MAX_LEN characters are loaded one character per handshake. The engine fills a DP matrix one cell per clock, backtraces, and presents the result length and the result string packed for direct display on an LCD row.
- It generalises the fixed 16-character, 8-bit, subsequence-only calculator: configurable length and character width, a substring mode, a load handshake with overflow protection, and a done/busy interface.

---
 rtl/lcs_engine_if.sv | 31 +++
 rtl/lcs_engine.sv | 265 ++++++++++++++++++++++++++
 tb/tb_lcs_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcs_engine_if.sv
// Load/start/result bundle shared by the LCS engine and whatever drives it.
// The master side loads characters and starts runs; the slave side is the engine.
interface lcs_engine_if #(
  parameter int MAX_LEN = 16,
  parameter int CHAR_W  = 8,
  parameter int LEN_W   = 5
);
  logic                      clear;
  logic                      load_valid;
  logic                      load_sel;
  logic [CHAR_W-1:0]         load_char;
  logic                      load_ready;
  logic                      mode;
  logic                      start;
  logic                      busy;
  logic                      done;
  logic [LEN_W-1:0]          len_a;
  logic [LEN_W-1:0]          len_b;
  logic [LEN_W-1:0]          res_len;
  logic [MAX_LEN*CHAR_W-1:0] res_str;

  modport master (
    output clear, load_valid, load_sel, load_char, mode, start,
    input  load_ready, busy, done, len_a, len_b, res_len, res_str
  );

  modport slave (
    input  clear, load_valid, load_sel, load_char, mode, start,
    output load_ready, busy, done, len_a, len_b, res_len, res_str
  );
endinterface

// File: rtl/lcs_engine.sv
// Longest common subsequence (mode 0) / substring (mode 1) engine: fills a DP
// matrix one cell per clock, then backtraces into an LCD-ready packed string.
module lcs_engine #(
  parameter int                MAX_LEN  = 16,
  parameter int                CHAR_W   = 8,
  parameter int                LEN_W    = 5,
  parameter logic [CHAR_W-1:0] PAD_CHAR = 8'h20
) (
  input logic         clk,
  input logic         reset,
  lcs_engine_if.slave bus
);

  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int MIDX_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] ZERO_L    = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] ONE_L     = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_TRACE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP   = 2'd0,
    DIR_LEFT = 2'd1,
    DIR_DIAG = 2'd2
  } dir_t;

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic              mode_r;
  logic [LEN_W-1:0]  len_a_r;
  logic [LEN_W-1:0]  len_b_r;
  logic [LEN_W-1:0]  res_len_r;
  logic [LEN_W-1:0]  tot_r;
  logic [LEN_W-1:0]  i_r;
  logic [LEN_W-1:0]  j_r;
  logic [LEN_W-1:0]  k_r;
  logic [LEN_W-1:0]  m_r;
  logic [LEN_W-1:0]  best_len_r;
  logic [LEN_W-1:0]  best_end_r;
  logic [CHAR_W-1:0] buf_a_r   [0:MAX_LEN-1];
  logic [CHAR_W-1:0] buf_b_r   [0:MAX_LEN-1];
  logic [CHAR_W-1:0] res_arr_r [0:MAX_LEN-1];
  logic [LEN_W-1:0]  l_mat_r   [0:MAX_LEN][0:MAX_LEN];
  dir_t              dir_mat_r [0:MAX_LEN][0:MAX_LEN];

  logic                      load_ready_s;
  logic [LEN_W-1:0]          im1_s;
  logic [LEN_W-1:0]          jm1_s;
  logic [CHAR_W-1:0]         a_prev_s;
  logic [CHAR_W-1:0]         b_prev_s;
  logic [CHAR_W-1:0]         a_cur_s;
  logic [LEN_W-1:0]          l_diag_s;
  logic [LEN_W-1:0]          l_up_s;
  logic [LEN_W-1:0]          l_left_s;
  logic [LEN_W-1:0]          cell_l_s;
  dir_t                      cell_dir_s;
  dir_t                      dir_cur_s;
  logic                      best_upd_s;
  logic [LEN_W-1:0]          best_nxt_len_s;
  logic [LEN_W-1:0]          best_nxt_end_s;
  logic                      last_cell_s;
  logic [MAX_LEN*CHAR_W-1:0] res_str_s;

  // Load handshake, current DP cell value/direction and running substring best.
  always_comb begin
    load_ready_s = 1'b0;
    if (busy_r) begin
      load_ready_s = 1'b0;
    end else if (bus.load_sel) begin
      load_ready_s = (len_b_r != MAX_LEN_L);
    end else begin
      load_ready_s = (len_a_r != MAX_LEN_L);
    end

    // Neighbour indices are clamped at row/column 0, where their values go unused.
    im1_s     = (i_r == ZERO_L) ? ZERO_L : (i_r - ONE_L);
    jm1_s     = (j_r == ZERO_L) ? ZERO_L : (j_r - ONE_L);
    a_prev_s  = buf_a_r[IDX_W'(im1_s)];
    b_prev_s  = buf_b_r[IDX_W'(jm1_s)];
    a_cur_s   = buf_a_r[IDX_W'(i_r)];
    l_diag_s  = l_mat_r[MIDX_W'(im1_s)][MIDX_W'(jm1_s)];
    l_up_s    = l_mat_r[MIDX_W'(im1_s)][MIDX_W'(j_r)];
    l_left_s  = l_mat_r[MIDX_W'(i_r)][MIDX_W'(jm1_s)];
    dir_cur_s = dir_mat_r[MIDX_W'(i_r)][MIDX_W'(j_r)];

    cell_l_s   = ZERO_L;
    cell_dir_s = DIR_UP;
    if ((i_r == ZERO_L) || (j_r == ZERO_L)) begin
      cell_l_s   = ZERO_L;
      cell_dir_s = DIR_UP;
    end else if (a_prev_s == b_prev_s) begin
      cell_l_s   = l_diag_s + ONE_L;
      cell_dir_s = DIR_DIAG;
    end else if (mode_r) begin
      cell_l_s   = ZERO_L;
      cell_dir_s = DIR_UP;
    end else if (l_up_s < l_left_s) begin
      cell_l_s   = l_left_s;
      cell_dir_s = DIR_LEFT;
    end else begin
      cell_l_s   = l_up_s;
      cell_dir_s = DIR_UP;
    end

    best_upd_s     = mode_r && (cell_l_s > best_len_r);
    best_nxt_len_s = best_upd_s ? cell_l_s : best_len_r;
    best_nxt_end_s = best_upd_s ? i_r : best_end_r;
    last_cell_s    = (i_r == len_a_r) && (j_r == len_b_r);

    res_str_s = {(MAX_LEN*CHAR_W){1'b0}};
    for (int n = 0; n < MAX_LEN; n++) begin
      res_str_s[(MAX_LEN-n)*CHAR_W-1 -: CHAR_W] = res_arr_r[n];
    end
  end

  assign bus.load_ready = load_ready_s;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.len_a      = len_a_r;
  assign bus.len_b      = len_b_r;
  assign bus.res_len    = res_len_r;
  assign bus.res_str    = res_str_s;

  // Control FSM: buffer loading in IDLE, matrix sweep in FILL, result build in TRACE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mode_r     <= 1'b0;
      len_a_r    <= ZERO_L;
      len_b_r    <= ZERO_L;
      res_len_r  <= ZERO_L;
      tot_r      <= ZERO_L;
      i_r        <= ZERO_L;
      j_r        <= ZERO_L;
      k_r        <= ZERO_L;
      m_r        <= ZERO_L;
      best_len_r <= ZERO_L;
      best_end_r <= ZERO_L;
      for (int n = 0; n < MAX_LEN; n++) begin
        buf_a_r[n]   <= PAD_CHAR;
        buf_b_r[n]   <= PAD_CHAR;
        res_arr_r[n] <= PAD_CHAR;
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.clear) begin
            len_a_r <= ZERO_L;
            len_b_r <= ZERO_L;
            for (int n = 0; n < MAX_LEN; n++) begin
              buf_a_r[n] <= PAD_CHAR;
              buf_b_r[n] <= PAD_CHAR;
            end
          end else if (bus.load_valid && load_ready_s) begin
            if (bus.load_sel) begin
              buf_b_r[IDX_W'(len_b_r)] <= bus.load_char;
              len_b_r                  <= len_b_r + ONE_L;
            end else begin
              buf_a_r[IDX_W'(len_a_r)] <= bus.load_char;
              len_a_r                  <= len_a_r + ONE_L;
            end
          end
          if (bus.start) begin
            mode_r     <= bus.mode;
            res_len_r  <= ZERO_L;
            i_r        <= ZERO_L;
            j_r        <= ZERO_L;
            best_len_r <= ZERO_L;
            best_end_r <= ZERO_L;
            busy_r     <= 1'b1;
            state_r    <= S_FILL;
            for (int n = 0; n < MAX_LEN; n++) begin
              res_arr_r[n] <= PAD_CHAR;
            end
          end
        end

        S_FILL: begin
          if (best_upd_s) begin
            best_len_r <= cell_l_s;
            best_end_r <= i_r;
          end
          if (last_cell_s) begin
            // An empty result skips TRACE entirely and signals done straight away.
            if (mode_r ? (best_nxt_len_s == ZERO_L) : (cell_l_s == ZERO_L)) begin
              state_r   <= S_IDLE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              res_len_r <= ZERO_L;
            end else if (mode_r) begin
              state_r <= S_TRACE;
              tot_r   <= best_nxt_len_s;
              k_r     <= best_nxt_len_s;
              m_r     <= ZERO_L;
              i_r     <= best_nxt_end_s - best_nxt_len_s;
            end else begin
              state_r <= S_TRACE;
              tot_r   <= cell_l_s;
              k_r     <= cell_l_s;
            end
          end else if (j_r == len_b_r) begin
            j_r <= ZERO_L;
            i_r <= i_r + ONE_L;
          end else begin
            j_r <= j_r + ONE_L;
          end
        end

        S_TRACE: begin
          if (mode_r) begin
            res_arr_r[IDX_W'(m_r)] <= a_cur_s;
            i_r                    <= i_r + ONE_L;
            m_r                    <= m_r + ONE_L;
            if ((m_r + ONE_L) == k_r) begin
              state_r   <= S_IDLE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              res_len_r <= tot_r;
            end
          end else begin
            case (dir_cur_s)
              DIR_DIAG: begin
                res_arr_r[IDX_W'(k_r - ONE_L)] <= a_prev_s;
                i_r <= i_r - ONE_L;
                j_r <= j_r - ONE_L;
                k_r <= k_r - ONE_L;
                if (k_r == ONE_L) begin
                  state_r   <= S_IDLE;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  res_len_r <= tot_r;
                end
              end
              DIR_LEFT: j_r <= j_r - ONE_L;
              default:  i_r <= i_r - ONE_L;
            endcase
          end
        end

        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // DP matrices are fully rewritten on every run before they are read, so no reset.
  always_ff @(posedge clk) begin
    if (state_r == S_FILL) begin
      l_mat_r[MIDX_W'(i_r)][MIDX_W'(j_r)]   <= cell_l_s;
      dir_mat_r[MIDX_W'(i_r)][MIDX_W'(j_r)] <= cell_dir_s;
    end
  end

endmodule

// File: tb/tb_lcs_engine.sv
// Self-checking bench for lcs_engine: directed scenarios plus randomized runs
// compared against a plain-arithmetic LCS / brute-force substring model.
module tb_lcs_engine;
  localparam int MAX_LEN = 16;
  localparam int CHAR_W  = 8;
  localparam int LEN_W   = 5;
  localparam logic [127:0] PAD_VEC = {16{8'h20}};

  typedef byte unsigned byte_q_t[$];

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int tests_run    = 0;
  int tests_failed = 0;

  lcs_engine_if #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .LEN_W(LEN_W)) bus ();

  lcs_engine #(
    .MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .LEN_W(LEN_W), .PAD_CHAR(8'h20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic byte_q_t to_q(input string s);
    byte_q_t q;
    for (int n = 0; n < s.len(); n++) q.push_back(s[n]);
    return q;
  endfunction

  function automatic logic [127:0] pack_q(input byte_q_t q);
    logic [127:0] v;
    v = PAD_VEC;
    for (int m = 0; m < q.size() && m < 16; m++) v[(16-m)*8-1 -: 8] = q[m];
    return v;
  endfunction

  // Reference: textbook LCS table with ties going up, or brute-force substring search.
  task automatic model(input byte_q_t a, input byte_q_t b, input bit md,
                       output int rlen, output logic [127:0] rstr, output int steps);
    int c[17][17];
    byte unsigned slots[16];
    int la, lb, ii, jj, kk, best, bend, run;
    la = a.size();
    lb = b.size();
    steps = 0;
    rstr = PAD_VEC;
    if (!md) begin
      for (int i = 0; i <= la; i++)
        for (int j = 0; j <= lb; j++) begin
          if (i == 0 || j == 0) c[i][j] = 0;
          else if (a[i-1] == b[j-1]) c[i][j] = c[i-1][j-1] + 1;
          else c[i][j] = (c[i-1][j] < c[i][j-1]) ? c[i][j-1] : c[i-1][j];
        end
      rlen = c[la][lb];
      for (int m = 0; m < 16; m++) slots[m] = 8'h20;
      ii = la; jj = lb; kk = rlen;
      while (kk > 0) begin
        steps++;
        if (a[ii-1] == b[jj-1]) begin
          slots[kk-1] = a[ii-1];
          ii--; jj--; kk--;
        end else if (c[ii-1][jj] < c[ii][jj-1]) jj--;
        else ii--;
      end
      for (int m = 0; m < 16; m++) rstr[(16-m)*8-1 -: 8] = slots[m];
    end else begin
      best = 0;
      bend = 0;
      for (int i = 1; i <= la; i++)
        for (int j = 1; j <= lb; j++) begin
          run = 0;
          while (run < i && run < j && a[i-1-run] == b[j-1-run]) run++;
          if (run > best) begin
            best = run;
            bend = i;
          end
        end
      rlen = best;
      steps = best;
      for (int m = 0; m < best; m++) rstr[(16-m)*8-1 -: 8] = a[bend-best+m];
    end
  endtask

  task automatic load_str(input bit sel, input byte_q_t s);
    for (int n = 0; n < s.size(); n++) begin
      bus.load_valid = 1'b1;
      bus.load_sel   = sel;
      bus.load_char  = s[n];
      tick();
    end
    bus.load_valid = 1'b0;
  endtask

  task automatic start_and_wait(input bit md, output int cyc, output bit got_done);
    bus.mode  = md;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 1000) begin
      if (bus.done) got_done = 1'b1;
      else begin
        cyc++;
        tick();
      end
    end
  endtask

  task automatic run_case(input byte_q_t a, input byte_q_t b, input bit md,
                          output int cyc, output bit got_done);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    load_str(1'b0, a);
    load_str(1'b1, b);
    start_and_wait(md, cyc, got_done);
  endtask

  task automatic test_reset();
    tests_run += 6;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus.done); end
    if (bus.len_a !== 5'd0 || bus.len_b !== 5'd0) begin
      tests_failed++; $display("FAIL reset_lens got %0d/%0d want 0/0", bus.len_a, bus.len_b);
    end
    if (bus.res_len !== 5'd0) begin tests_failed++; $display("FAIL reset_res_len got %0d want 0", bus.res_len); end
    if (bus.res_str !== PAD_VEC) begin tests_failed++; $display("FAIL reset_res_str got %h want %h", bus.res_str, PAD_VEC); end
    if (bus.load_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_load_ready got %b want 1", bus.load_ready); end
  endtask

  task automatic test_load_clear();
    load_str(1'b1, to_q("QRS"));
    tests_run++;
    if (bus.len_b !== 5'd3) begin tests_failed++; $display("FAIL load_len_b got %0d want 3", bus.len_b); end
    bus.clear = 1'b1; bus.load_valid = 1'b1; bus.load_sel = 1'b0; bus.load_char = 8'h41;
    tick();
    bus.clear = 1'b0; bus.load_valid = 1'b0;
    tests_run++;
    if (bus.len_a !== 5'd0 || bus.len_b !== 5'd0) begin
      tests_failed++; $display("FAIL clear_wins got %0d/%0d want 0/0", bus.len_a, bus.len_b);
    end
  endtask

  task automatic test_lcs_example();
    byte_q_t a, b;
    int cyc, elen, esteps;
    bit got;
    logic [127:0] estr;
    a = to_q("ABCBDAB");
    b = to_q("BDCABA");
    model(a, b, 1'b0, elen, estr, esteps);
    run_case(a, b, 1'b0, cyc, got);
    tests_run += 6;
    if (got !== 1'b1) begin tests_failed++; $display("FAIL lcs_done timeout got %b want 1", got); end
    if (bus.res_len !== 5'd4) begin tests_failed++; $display("FAIL lcs_res_len got %0d want 4", bus.res_len); end
    if (bus.res_str !== pack_q(to_q("BCBA"))) begin tests_failed++; $display("FAIL lcs_res_str got %h want BCBA padded", bus.res_str); end
    if (cyc !== 56 + esteps) begin tests_failed++; $display("FAIL lcs_cycles got %0d want %0d", cyc, 56 + esteps); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL lcs_busy_at_done got %b want 0", bus.busy); end
    tick();
    if (bus.done !== 1'b0 || bus.res_len !== 5'd4) begin
      tests_failed++; $display("FAIL lcs_done_pulse got done=%b len=%0d want 0/4", bus.done, bus.res_len);
    end
  endtask

  task automatic test_substring();
    byte_q_t a, b;
    int cyc;
    bit got;
    a = to_q("XABCDY");
    b = to_q("ZZABCDQ");
    run_case(a, b, 1'b1, cyc, got);
    tests_run += 3;
    if (got !== 1'b1 || bus.res_len !== 5'd4) begin tests_failed++; $display("FAIL substr_len got %0d want 4", bus.res_len); end
    if (bus.res_str !== pack_q(to_q("ABCD"))) begin tests_failed++; $display("FAIL substr_str got %h want ABCD padded", bus.res_str); end
    if (cyc !== 56 + 4) begin tests_failed++; $display("FAIL substr_cycles got %0d want 60", cyc); end
  endtask

  task automatic test_substring_tie();
    int cyc;
    bit got;
    run_case(to_q("ABXCD"), to_q("CDAB"), 1'b1, cyc, got);
    tests_run += 2;
    if (got !== 1'b1 || bus.res_len !== 5'd2) begin tests_failed++; $display("FAIL tie_len got %0d want 2", bus.res_len); end
    if (bus.res_str !== pack_q(to_q("AB"))) begin tests_failed++; $display("FAIL tie_str got %h want AB padded", bus.res_str); end
  endtask

  task automatic test_overflow();
    byte_q_t a;
    int not_ready, cyc;
    bit got;
    a = to_q("ABCDEFGHIJKLMNOP");
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    not_ready = 0;
    for (int n = 0; n < 16; n++) begin
      bus.load_valid = 1'b1; bus.load_sel = 1'b0; bus.load_char = a[n];
      #1;
      if (bus.load_ready !== 1'b1) not_ready++;
      tick();
    end
    bus.load_valid = 1'b0;
    tests_run += 4;
    if (not_ready != 0) begin tests_failed++; $display("FAIL ovf_ready_early got %0d low want 0", not_ready); end
    bus.load_sel = 1'b0;
    #1;
    if (bus.load_ready !== 1'b0) begin tests_failed++; $display("FAIL ovf_ready_full got %b want 0", bus.load_ready); end
    bus.load_sel = 1'b1;
    #1;
    if (bus.load_ready !== 1'b1) begin tests_failed++; $display("FAIL ovf_ready_other got %b want 1", bus.load_ready); end
    bus.load_valid = 1'b1; bus.load_sel = 1'b0; bus.load_char = 8'h5A;
    tick();
    bus.load_valid = 1'b0;
    if (bus.len_a !== 5'd16) begin tests_failed++; $display("FAIL ovf_len_a got %0d want 16", bus.len_a); end
    load_str(1'b1, a);
    start_and_wait(1'b1, cyc, got);
    tests_run += 2;
    if (got !== 1'b1 || bus.res_len !== 5'd16) begin tests_failed++; $display("FAIL ovf_res_len got %0d want 16", bus.res_len); end
    if (bus.res_str !== pack_q(a)) begin tests_failed++; $display("FAIL ovf_buffer got %h want %h", bus.res_str, pack_q(a)); end
  endtask

  task automatic test_empty_and_busy();
    int dones, first;
    logic [4:0] rlen;
    logic [127:0] rstr;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    load_str(1'b0, to_q("HELLO"));
    bus.mode = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests_run += 2;
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL empty_busy got %b want 1", bus.busy); end
    if (bus.load_ready !== 1'b0) begin tests_failed++; $display("FAIL busy_load_ready got %b want 0", bus.load_ready); end
    dones = 0; first = -1; rlen = 5'h1F; rstr = '0;
    for (int c = 1; c <= 30; c++) begin
      bus.start = (c == 2);
      bus.clear = (c == 2);
      tick();
      if (bus.done) begin
        dones++;
        if (first < 0) begin first = c; rlen = bus.res_len; rstr = bus.res_str; end
      end
    end
    bus.start = 1'b0; bus.clear = 1'b0;
    tests_run += 5;
    if (dones !== 1) begin tests_failed++; $display("FAIL busy_start_dones got %0d want 1", dones); end
    if (first !== 6) begin tests_failed++; $display("FAIL empty_cycles got %0d want 6", first); end
    if (rlen !== 5'd0) begin tests_failed++; $display("FAIL empty_res_len got %0d want 0", rlen); end
    if (rstr !== PAD_VEC) begin tests_failed++; $display("FAIL empty_res_str got %h want %h", rstr, PAD_VEC); end
    if (bus.len_a !== 5'd5) begin tests_failed++; $display("FAIL busy_clear_ignored got %0d want 5", bus.len_a); end
  endtask

  task automatic test_reset_mid_fill();
    int dones, cyc;
    bit got;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    load_str(1'b0, to_q("ABCBDAB"));
    load_str(1'b1, to_q("BDCABA"));
    bus.mode = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run += 4;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL abort_busy_done got %b/%b want 0/0", bus.busy, bus.done);
    end
    if (bus.len_a !== 5'd0 || bus.len_b !== 5'd0) begin
      tests_failed++; $display("FAIL abort_lens got %0d/%0d want 0/0", bus.len_a, bus.len_b);
    end
    if (bus.res_str !== PAD_VEC || bus.res_len !== 5'd0) begin
      tests_failed++; $display("FAIL abort_result got %h len %0d want pad/0", bus.res_str, bus.res_len);
    end
    dones = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (bus.done) dones++;
    end
    if (dones !== 0) begin tests_failed++; $display("FAIL abort_no_done got %0d want 0", dones); end
    run_case(to_q("ABCBDAB"), to_q("BDCABA"), 1'b0, cyc, got);
    tests_run++;
    if (got !== 1'b1 || bus.res_str !== pack_q(to_q("BCBA")) || bus.res_len !== 5'd4) begin
      tests_failed++; $display("FAIL abort_rerun got %h len %0d want BCBA/4", bus.res_str, bus.res_len);
    end
  endtask

  task automatic test_random_and_back_to_back();
    byte_q_t a, b;
    int la, lb, cyc, elen, esteps;
    bit md, got;
    logic [127:0] estr;
    for (int it = 0; it < 30; it++) begin
      a.delete();
      b.delete();
      la = (it % 7 == 3) ? 0 : $urandom_range(0, 16);
      lb = (it % 7 == 5) ? 0 : $urandom_range(0, 16);
      for (int n = 0; n < la; n++) a.push_back(8'h41 + 8'($urandom_range(0, 3)));
      for (int n = 0; n < lb; n++) b.push_back(8'h41 + 8'($urandom_range(0, 3)));
      md = 1'($urandom_range(0, 1));
      model(a, b, md, elen, estr, esteps);
      run_case(a, b, md, cyc, got);
      tests_run++;
      if (got !== 1'b1 || bus.res_len !== 5'(elen) || bus.res_str !== estr ||
          cyc !== (la + 1) * (lb + 1) + esteps) begin
        tests_failed++;
        $display("FAIL random[%0d] mode %0d got len %0d cyc %0d str %h want len %0d cyc %0d str %h",
                 it, md, bus.res_len, cyc, bus.res_str, elen, (la + 1) * (lb + 1) + esteps, estr);
      end
      if (it % 10 == 9) begin
        // Restart in the done cycle itself: the engine is already idle then.
        start_and_wait(md, cyc, got);
        tests_run++;
        if (got !== 1'b1 || bus.res_len !== 5'(elen) || bus.res_str !== estr) begin
          tests_failed++;
          $display("FAIL back_to_back[%0d] got len %0d str %h want len %0d str %h",
                   it, bus.res_len, bus.res_str, elen, estr);
        end
      end
    end
  endtask

  initial begin
    bus.clear = 1'b0; bus.load_valid = 1'b0; bus.load_sel = 1'b0;
    bus.load_char = 8'h00; bus.mode = 1'b0; bus.start = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_load_clear();
    test_lcs_example();
    test_substring();
    test_substring_tie();
    test_overflow();
    test_empty_and_busy();
    test_reset_mid_fill();
    test_random_and_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
